// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch master: FSM states and prefetch buffer entry.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package ifetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // One buffered fetch: the word and the address it was read from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Fetch addresses are word aligned; low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/naive_bus_if.sv
// Simple split read/write bus; the fetch master only uses the read channel.
// Latency: read data valid exactly one cycle after the rd_req & rd_gnt cycle.
// Backpressure: slave stalls a read by holding rd_gnt low; master keeps rd_req/rd_addr stable.
// Ports: rd_req/rd_gnt/rd_be/rd_addr/rd_data (read), wr_req/wr_be/wr_addr/wr_data (write).
interface naive_bus;

    logic        rd_req;
    logic        rd_gnt;
    logic [3:0]  rd_be;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;

    logic        wr_req;
    logic [3:0]  wr_be;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output rd_req, rd_be, rd_addr,
        output wr_req, wr_be, wr_addr, wr_data,
        input  rd_gnt, rd_data
    );

    modport slave (
        input  rd_req, rd_be, rd_addr,
        input  wr_req, wr_be, wr_addr, wr_data,
        output rd_gnt, rd_data
    );

endinterface

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: power-of-two deep FIFO of fetch entries with synchronous flush.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is dropped only when full with no pop; flush wins over push and pop.
// Ports: clk, rst_n, push/push_dat, pop, flush, head_dat, full, empty, count.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head_dat,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        // Full buffer still accepts a push when the head leaves this cycle.
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are PW bits wide, so they wrap modulo DEPTH naturally.
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is presented while count is zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/ibus_fetch_master.sv
// Instruction fetch master: sequential prefetch over naive_bus into a small buffer, with redirect.
// Latency: issue -> out_valid two cycles (one when IFETCH_BYPASS_EN is defined and buffer empty).
// Backpressure: stops issuing when buffered + in-flight entries reach FIFO_DEPTH; out_ready pops.
// Ports: clk, rst_n, redirect/redirect_pc, out_valid/out_ready/out_pc/out_instr, bus (naive_bus.master).
// Build option: define IFETCH_BYPASS_EN to hand a response straight to the consumer when empty.
module ibus_fetch_master
    import ifetch_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    naive_bus.master    bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         resp_pending_q, resp_pending_d;
    logic [31:0]  resp_pc_q, resp_pc_d;
    logic         discard_q, discard_d;

    logic          flush_req;
    logic          credit_ok;
    logic          rd_req;
    logic          issue;
    logic          resp_keep;
    logic          bypass_vld;
    logic          fifo_push;
    logic          fifo_pop;
    fetch_entry_t  resp_entry;
    fetch_entry_t  fifo_head;
    fetch_entry_t  out_entry;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // Redirect in BOOT only replaces the start address; no flush is needed there.
    assign flush_req = redirect & (state_q != BOOT);

    // Reserve a slot for the in-flight response; a pop this cycle is not credited.
    assign credit_ok = ~fifo_full &
                       ((fifo_count + CW'(resp_pending_q)) < CW'(FIFO_DEPTH));

    assign rd_req = (state_q == RUN) & ~redirect & credit_ok;
    assign issue  = rd_req & bus.rd_gnt;

    // A returning response is kept unless a flush is in progress or was just requested.
    assign resp_keep  = resp_pending_q & ~discard_q & ~flush_req;
    assign resp_entry = '{pc: resp_pc_q, instr: bus.rd_data};

`ifdef IFETCH_BYPASS_EN
    assign bypass_vld = resp_keep & fifo_empty;
`else
    assign bypass_vld = 1'b0;
`endif

    // A bypassed response is only buffered if the consumer did not take it.
    assign fifo_push = resp_keep & ~(bypass_vld & out_ready);
    assign fifo_pop  = ~fifo_empty & out_ready;

    assign out_valid = ~fifo_empty | bypass_vld;
    assign out_entry = fifo_empty ? resp_entry : fifo_head;
    assign out_pc    = out_valid ? out_entry.pc    : 32'h0;
    assign out_instr = out_valid ? out_entry.instr : 32'h0;

    assign bus.rd_req  = rd_req;
    assign bus.rd_addr = rd_req ? fetch_pc_q : 32'h0;
    assign bus.rd_be   = 4'hF;
    assign bus.wr_req  = 1'b0;
    assign bus.wr_be   = 4'h0;
    assign bus.wr_addr = 32'h0;
    assign bus.wr_data = 32'h0;

    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        resp_pending_d = issue;
        resp_pc_d      = issue ? fetch_pc_q : resp_pc_q;
        discard_d      = 1'b0;
        case (state_q)
            BOOT: begin
                state_d    = RUN;
                fetch_pc_d = redirect ? align_pc(redirect_pc) : BOOT_ADDR;
            end
            RUN: begin
                if (redirect) begin
                    state_d    = DRAIN;
                    fetch_pc_d = align_pc(redirect_pc);
                    discard_d  = 1'b1;
                end else if (issue) begin
                    // 32-bit add wraps 0xFFFF_FFFC to 0 on its own.
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetch_pc_d = align_pc(redirect_pc);
                    discard_d  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= BOOT;
            fetch_pc_q     <= BOOT_ADDR;
            resp_pending_q <= 1'b0;
            resp_pc_q      <= 32'h0;
            discard_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            resp_pending_q <= resp_pending_d;
            resp_pc_q      <= resp_pc_d;
            discard_q      <= discard_d;
        end
    end

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (resp_entry),
        .pop      (fifo_pop),
        .flush    (flush_req),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_ibus_fetch_master.sv
// Directed bench for ibus_fetch_master (default build, FIFO_DEPTH=4, BOOT_ADDR=0).
// A slave model records every granted read in a scoreboard queue; a monitor pops on each accept.
// Directed steps also check bus signals and outputs at known cycles.
module tb_ibus_fetch_master;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        gnt;
    logic [31:0] slv_data = 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;
    int issue_cnt = 0;
    fetch_entry_t exp_q[$];

    naive_bus bus_i ();
    assign bus_i.rd_gnt  = gnt;
    assign bus_i.rd_data = slv_data;

    ibus_fetch_master dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .bus         (bus_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Slave: always answers one cycle after the granting edge; idle data is poison.
    always @(posedge clk) begin
        if (bus_i.rd_req && bus_i.rd_gnt) begin
            exp_q.push_back('{pc: bus_i.rd_addr, instr: mem_word(bus_i.rd_addr)});
            issue_cnt++;
            slv_data <= mem_word(bus_i.rd_addr);
        end else begin
            slv_data <= 32'hDEAD_BEEF;
        end
    end

    // Consumer side: every accepted entry must be the oldest unflushed granted read.
    always @(negedge clk) begin
        fetch_entry_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_out", out_pc, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", out_pc, e.pc);
                    chk("sb_instr", out_instr, e.instr);
                end
            end
            if (redirect) exp_q.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b1;
        gnt         = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_rd_req", {31'h0, bus_i.rd_req}, 32'h0);
        chk("rst_rd_addr", bus_i.rd_addr, 32'h0);
        chk("rst_wr_req", {31'h0, bus_i.wr_req}, 32'h0);
        chk("rst_wr_data", bus_i.wr_data, 32'h0);

        // Streaming start: one BOOT cycle, then 0,4,8; first output two cycles after issue
        step(); rst_n = 1'b1;
        @(negedge clk); chk("boot_rd_req", {31'h0, bus_i.rd_req}, 32'h0);
        step(); @(negedge clk);
        chk("s_rd_req", {31'h0, bus_i.rd_req}, 32'h1);
        chk("s_rd_addr0", bus_i.rd_addr, 32'h0);
        chk("s_rd_be", {28'h0, bus_i.rd_be}, 32'hF);
        step(); @(negedge clk);
        chk("s_rd_addr4", bus_i.rd_addr, 32'h4);
        chk("s_valid_early", {31'h0, out_valid}, 32'h0);
        step(); @(negedge clk);
        chk("s_rd_addr8", bus_i.rd_addr, 32'h8);
        chk("s_valid", {31'h0, out_valid}, 32'h1);
        chk("s_out_pc0", out_pc, 32'h0);
        chk("s_out_instr0", out_instr, mem_word(32'h0));

        // Full buffer: exactly FIFO_DEPTH reads then stop; resume at 0x10
        step(); redirect = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0; issue_cnt = 0;
        @(negedge clk); chk("f_redir_rd_req", {31'h0, bus_i.rd_req}, 32'h0);
        step(); redirect = 1'b0;
        @(negedge clk);
        chk("f_drain_rd_req", {31'h0, bus_i.rd_req}, 32'h0);
        chk("f_drain_valid", {31'h0, out_valid}, 32'h0);
        repeat (6) step();
        @(negedge clk);
        chk("f_issue_cnt", issue_cnt, 32'd4);
        chk("f_rd_req_stop", {31'h0, bus_i.rd_req}, 32'h0);
        chk("f_out_pc", out_pc, 32'h0);
        step(); out_ready = 1'b1;
        @(negedge clk); chk("f_pop_not_credited", {31'h0, bus_i.rd_req}, 32'h0);
        step(); @(negedge clk);
        chk("f_resume_req", {31'h0, bus_i.rd_req}, 32'h1);
        chk("f_resume_addr", bus_i.rd_addr, 32'h10);

        // Grant stall at 0x8 for three cycles
        step(); redirect = 1'b1; redirect_pc = 32'h0;
        step(); redirect = 1'b0;
        step(); @(negedge clk); chk("g_addr0", bus_i.rd_addr, 32'h0);
        step(); @(negedge clk); chk("g_addr4", bus_i.rd_addr, 32'h4);
        step(); gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                @(posedge clk); #1; gnt = 1'b1;
            end else if (i > 0) begin
                step();
            end
            @(negedge clk);
            chk("g_stall_req", {31'h0, bus_i.rd_req}, 32'h1);
            chk("g_stall_addr", bus_i.rd_addr, 32'h8);
        end
        step(); @(negedge clk); chk("g_after_addr", bus_i.rd_addr, 32'hC);

        // Redirect with a read to 0x20 in flight
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(); @(negedge clk);
            if (bus_i.rd_req && bus_i.rd_addr == 32'h20) found = 1'b1;
        end
        chk("r_found_0x20", {31'h0, found}, 32'h1);
        step(); redirect = 1'b1; redirect_pc = 32'h103;
        @(negedge clk); chk("r_redir_rd_req", {31'h0, bus_i.rd_req}, 32'h0);
        step(); redirect = 1'b0;
        @(negedge clk);
        chk("r_drain_valid", {31'h0, out_valid}, 32'h0);
        chk("r_drain_rd_req", {31'h0, bus_i.rd_req}, 32'h0);
        step(); @(negedge clk); chk("r_addr_100", bus_i.rd_addr, 32'h100);
        step(); @(negedge clk); chk("r_valid_early", {31'h0, out_valid}, 32'h0);
        step(); @(negedge clk); chk("r_out_pc_100", out_pc, 32'h100);

        // Address wrap
        step(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step(); redirect = 1'b0;
        step(); @(negedge clk); chk("w_addr_fff8", bus_i.rd_addr, 32'hFFFF_FFF8);
        step(); @(negedge clk); chk("w_addr_fffc", bus_i.rd_addr, 32'hFFFF_FFFC);
        step(); @(negedge clk);
        chk("w_addr_0", bus_i.rd_addr, 32'h0);
        chk("w_out_fff8", out_pc, 32'hFFFF_FFF8);
        step(); @(negedge clk);
        chk("w_addr_4", bus_i.rd_addr, 32'h4);
        chk("w_out_fffc", out_pc, 32'hFFFF_FFFC);
        step(); @(negedge clk); chk("w_out_0", out_pc, 32'h0);

        // Reset with three buffered entries and one read in flight
        step(); redirect = 1'b1; redirect_pc = 32'h200; out_ready = 1'b0;
        step(); redirect = 1'b0;
        step(); @(negedge clk); chk("x_addr_200", bus_i.rd_addr, 32'h200);
        repeat (3) step();
        @(negedge clk); chk("x_addr_20c", bus_i.rd_addr, 32'h20C);
        step(); @(negedge clk);
        chk("x_full_rd_req", {31'h0, bus_i.rd_req}, 32'h0);
        chk("x_head_pc", out_pc, 32'h200);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("x_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("x_rst_pc", out_pc, 32'h0);
        chk("x_rst_instr", out_instr, 32'h0);
        chk("x_rst_rd_req", {31'h0, bus_i.rd_req}, 32'h0);
        chk("x_rst_rd_addr", bus_i.rd_addr, 32'h0);
        repeat (2) step();
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("x_boot_rd_req", {31'h0, bus_i.rd_req}, 32'h0);
        chk("x_boot_valid", {31'h0, out_valid}, 32'h0);
        step(); @(negedge clk); chk("x_refetch_addr", bus_i.rd_addr, 32'h0);
        step(); @(negedge clk); chk("x_refetch_valid_early", {31'h0, out_valid}, 32'h0);
        step(); @(negedge clk);
        chk("x_refetch_out_pc", out_pc, 32'h0);
        chk("x_refetch_instr", out_instr, mem_word(32'h0));

        // Redirect during BOOT only replaces the start address (low bits dropped)
        step(); rst_n = 1'b0; exp_q.delete();
        step(); rst_n = 1'b1; redirect = 1'b1; redirect_pc = 32'h47;
        @(negedge clk); chk("b_boot_rd_req", {31'h0, bus_i.rd_req}, 32'h0);
        step(); redirect = 1'b0;
        @(negedge clk); chk("b_addr_44", bus_i.rd_addr, 32'h44);
        repeat (2) step();
        @(negedge clk); chk("b_out_pc_44", out_pc, 32'h44);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibus_fetch_master.md
IBUS_FETCH_MASTER -- requirements
Module: ibus_fetch_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, prefetch buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have redirect  input  1  flush and restart fetch at redirect_pc.
REQ-006 SHALL have redirect_pc  input  32  new fetch address; bits [1:0] ignored, treated as 00.
REQ-007 SHALL have out_valid  output  1  out_pc/out_instr hold a fetched instruction.
REQ-008 SHALL have out_ready  input  1  consumer accepts the entry when out_valid & out_ready.
REQ-009 SHALL have out_pc  output  32  address of the presented instruction.
REQ-010 SHALL have out_instr  output  32  presented instruction word.
REQ-011 SHALL have bus  naive_bus.master  --  instruction bus master port (read channel used).

Function
REQ-012 SHALL drive bus.rd_be = 4'hF on every read; wr_req, wr_be, wr_addr, wr_data SHALL be constant 0.
REQ-013 SHALL hold rd_req high with stable rd_addr until the cycle rd_gnt is sampled high; a read is issued when rd_req & rd_gnt.
REQ-014 SHALL capture bus.rd_data exactly one cycle after the issuing cycle (1-cycle response latency), tagged with the issued address.
REQ-015 SHALL keep at most one read outstanding (resp_pending flag); a new read may issue in the same cycle a response returns.
REQ-016 SHALL issue only when fifo_count + resp_pending < FIFO_DEPTH (pop in same cycle not credited).
REQ-017 SHALL advance fetch_pc by 4 on each issue; wrap from 32'hFFFF_FFFC to 0 without error.
REQ-018 SHALL implement FSM BOOT -> RUN: BOOT lasts exactly one cycle after reset release with rd_req=0, loads fetch_pc=BOOT_ADDR; RUN issues per REQ-016.
REQ-019 SHALL in RUN also enter DRAIN on redirect: redirect cycle drives rd_req=0, clears FIFO, loads fetch_pc=redirect_pc&~3; DRAIN lasts one cycle, discarding any response returning then, then returns to RUN.
REQ-020 SHALL give redirect priority over push, pop and issue in the same cycle; a pop coinciding with redirect is still counted as accepted by the consumer.
REQ-021 SHALL ignore redirect during BOOT except to replace BOOT_ADDR with redirect_pc.
REQ-022 SHALL present FIFO head on out_pc/out_instr when out_valid; outputs SHALL be 0 when out_valid=0.
REQ-023 SHALL support simultaneous push and pop when full (count unchanged); push when full SHALL never occur by construction.
REQ-024 SHALL keep pointers FIFO_DEPTH-modulo with a count of width $clog2(FIFO_DEPTH)+1.

Reset
REQ-025 SHALL on rst_n=0 asynchronously set: state=BOOT, fetch_pc=BOOT_ADDR, count/pointers=0, resp_pending=0, discard=0, rd_req=0, rd_addr=0, out_valid=0, out_pc=0, out_instr=0.
REQ-026 SHALL drop any in-flight read on reset mid-operation; its response SHALL never be pushed.

Configuration
REQ-027 SHALL, with IFETCH_BYPASS_EN defined, route a returning response directly to out_* in its arrival cycle when FIFO empty and no redirect (out_valid same cycle as rd_data); pushed only if out_ready=0.
REQ-028 SHALL, without IFETCH_BYPASS_EN, always push responses; earliest out_valid is the cycle after rd_data.

Structure
REQ-029 SHALL place FSM state enum (BOOT, RUN, DRAIN) and fifo entry typedef {pc, instr} in shared package ifetch_pkg.
REQ-030 SHALL implement the buffer as sub-module ifetch_fifo (parameterised depth, push/pop/flush, full/empty/count).

Verification
REQ-031 Reset release, BOOT_ADDR=0, slave always granting, out_ready=1 -> rd_addr 0,4,8 on consecutive cycles; out_pc 0 with instr from addr 0 two cycles after first issue (one with bypass).
REQ-032 out_ready=0, DEPTH=4 -> exactly 4 reads issued, rd_req then 0; raising out_ready resumes issue at addr 0x10.
REQ-033 rd_gnt held 0 for 3 cycles at addr 0x8 -> rd_req and rd_addr=0x8 stable for 4 cycles, single response pushed.
REQ-034 redirect to 0x103 while a read to 0x20 is outstanding -> response for 0x20 discarded, FIFO empty, next issue rd_addr=0x100, out_pc 0x100 first.
REQ-035 fetch_pc=0xFFFF_FFFC -> next issues 0xFFFF_FFFC then 0x0000_0000, out_pc follows.
REQ-036 rst_n pulsed low with 3 entries buffered and one read outstanding -> all outputs 0 immediately, refetch from BOOT_ADDR after one BOOT cycle.
